if_stage_ctrl: RTL and testbench

IF_STAGE_CTRL -- requirements
Module: if_stage_ctrl

---
 rtl/rv32_pipe_pkg.sv | 31 +++
 rtl/if_hold_buf.sv | 50 +++++
 rtl/if_stage_ctrl.sv | 155 +++++++++++++++
 tb/tb_if_stage_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_pipe_pkg.sv
// Shared constants and types for the RV32 fetch pipeline.
// Holds the NOP encoding, the default reset PC, the fetch FSM encoding and the IF/ID record.
package rv32_pipe_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FULL = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    // A bubble keeps the previous PC so downstream debug still sees where the stream stood.
    function automatic ifid_t ifid_bubble(input logic [31:0] pc);
        ifid_t b;
        b.pc    = pc;
        b.instr = NOP_INSTR;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer that parks a fetched instruction while IF/ID is stalled.
// Clear wins over load; the controller never asserts both in the same cycle.
module if_hold_buf
    import rv32_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        full_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        full_q,  full_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;

    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage controller: single outstanding fetch, redirect with kill, IF/ID register.
//
//   state | meaning
//   IDLE  | no fetch in flight, waiting for PCWrite
//   REQ   | imem_req asserted at addr_q, waiting for imem_gnt
//   WAIT  | request granted, waiting for imem_rvalid
//   FULL  | response parked in hold buffer, waiting for IFIDWrite
module if_stage_ctrl
    import rv32_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        IF_Flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_IFID,
    output logic [31:0] instr_IFID,
    output logic        valid_IFID
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic        imem_req_q;
    ifid_t       ifid_q, ifid_d;

    logic        redirect;
    logic        resp_keep;
    logic        deliver_wait;
    logic        deliver_buf;
    logic        buf_load;
    logic        buf_clear;
    logic        buf_full;
    logic [31:0] buf_pc;
    logic [31:0] buf_instr;

    assign redirect = branch_taken & PCWrite;

    // A redirect in the same cycle as the response makes that response old-path too.
    assign resp_keep    = (state_q == ST_WAIT) & imem_rvalid & ~kill_q & ~redirect;
    assign deliver_wait = resp_keep & IFIDWrite & ~IF_Flush;
    assign buf_load     = resp_keep & ~IFIDWrite;
    assign deliver_buf  = (state_q == ST_FULL) & buf_full & IFIDWrite & ~IF_Flush & ~redirect;
    assign buf_clear    = (state_q == ST_FULL) & (IFIDWrite | redirect);

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .pc_i    (req_pc_q),
        .instr_i (imem_rdata),
        .full_o  (buf_full),
        .pc_o    (buf_pc),
        .instr_o (buf_instr)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        req_pc_d = req_pc_q;
        kill_d   = kill_q;

        unique case (state_q)
            ST_IDLE: begin
                if (PCWrite) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    req_pc_d = addr_q;
                    // With kill pending, pc already holds the redirect target.
                    if (!kill_q) pc_d = pc_q + PC_STEP;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    kill_d = 1'b0;
                    if (buf_load)     state_d = ST_FULL;
                    else if (PCWrite) state_d = ST_REQ;
                    else              state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (redirect)       state_d = ST_REQ;
                else if (IFIDWrite) state_d = PCWrite ? ST_REQ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect) begin
            pc_d = branch_target;
            if ((state_q == ST_REQ) || ((state_q == ST_WAIT) && !imem_rvalid)) kill_d = 1'b1;
        end

        // The request address is frozen on entry to REQ so it stays stable until gnt.
        if ((state_d == ST_REQ) && (state_q != ST_REQ)) addr_d = pc_d;
    end

    always_comb begin
        ifid_d = ifid_q;
        if (IFIDWrite) begin
            if (deliver_wait) begin
                ifid_d.pc    = req_pc_q;
                ifid_d.instr = imem_rdata;
                ifid_d.valid = 1'b1;
            end else if (deliver_buf) begin
                ifid_d.pc    = buf_pc;
                ifid_d.instr = buf_instr;
                ifid_d.valid = 1'b1;
            end else begin
                ifid_d = ifid_bubble(ifid_q.pc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_pc_q   <= '0;
            kill_q     <= 1'b0;
            imem_req_q <= 1'b0;
            ifid_q     <= ifid_bubble(32'h0);
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
            imem_req_q <= (state_d == ST_REQ);
            ifid_q     <= ifid_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = addr_q;
    assign pc_IFID    = ifid_q.pc;
    assign instr_IFID = ifid_q.instr;
    assign valid_IFID = ifid_q.valid;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl with a small one-outstanding memory responder.
module tb_if_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCWrite, IFIDWrite, IF_Flush, branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_IFID, instr_IFID;
    logic        valid_IFID;

    int n_checks = 0;
    int n_errors = 0;

    logic        gnt_en   = 1'b1;
    logic        hold_rv  = 1'b0;
    logic        stray_rv = 1'b0;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        seen_bad = 1'b0;

    if_stage_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IF_Flush      (IF_Flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .pc_IFID       (pc_IFID),
        .instr_IFID    (instr_IFID),
        .valid_IFID    (valid_IFID)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h8) return 32'h00A0_0093;
        return {16'hA5A5, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive the responder, take the edge, then update its bookkeeping.
    task automatic cycle();
        logic        fire_gnt, fire_rv;
        logic [31:0] ga;
        imem_gnt    = gnt_en;
        imem_rvalid = (pend && !hold_rv) || (stray_rv && !pend);
        imem_rdata  = pend ? mem(pend_addr) : 32'hBAD0_0001;
        fire_rv  = pend && !hold_rv;
        fire_gnt = imem_req && imem_gnt;
        ga       = imem_addr;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (fire_rv) pend = 1'b0;
            if (fire_gnt) begin
                pend      = 1'b1;
                pend_addr = ga;
            end
        end
        if (valid_IFID && (instr_IFID == 32'hA5A5_000C || instr_IFID == 32'hA5A5_0104 ||
                           instr_IFID == 32'hBAD0_0001))
            seen_bad = 1'b1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic v);
        chk({tag, "_pc"}, pc_IFID, pc);
        chk({tag, "_instr"}, instr_IFID, ins);
        chk({tag, "_valid"}, 32'(valid_IFID), 32'(v));
    endtask

    initial begin
        rst_n = 1'b0; PCWrite = 1'b1; IFIDWrite = 1'b1; IF_Flush = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        #1;
        cycle(); cycle();
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        check_ifid("rst", 32'h0, 32'h13, 1'b0);

        // Streaming: IDLE, REQ, WAIT, then valid in the 4th cycle after release.
        rst_n = 1'b1;
        cycle();
        chk("s1_req", 32'(imem_req), 32'h1);
        chk("s1_addr", imem_addr, 32'h0);
        cycle();
        chk("s2_valid", 32'(valid_IFID), 32'h0);
        cycle();
        check_ifid("s3", 32'h0, 32'hA5A5_0000, 1'b1);
        cycle();
        check_ifid("s4", 32'h0, 32'h13, 1'b0);
        cycle();
        check_ifid("s5", 32'h4, 32'hA5A5_0004, 1'b1);
        cycle();

        // Stall while the response for pc 0x8 arrives.
        IFIDWrite = 1'b0;
        cycle(); cycle(); cycle();
        chk("stall_req", 32'(imem_req), 32'h0);
        check_ifid("stall", 32'h4, 32'h13, 1'b0);
        IFIDWrite = 1'b1;
        cycle();
        check_ifid("rel", 32'h8, 32'h00A0_0093, 1'b1);
        chk("rel_addr", imem_addr, 32'hC);
        cycle();
        chk("rel_once", 32'(valid_IFID), 32'h0);

        // Redirect in WAIT; the response for 0xC must vanish.
        hold_rv = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
        cycle();
        hold_rv = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        cycle();
        chk("br_addr", imem_addr, 32'h100);
        chk("br_req", 32'(imem_req), 32'h1);
        chk("br_valid", 32'(valid_IFID), 32'h0);
        cycle(); cycle();
        check_ifid("br_tgt", 32'h100, 32'hA5A5_0100, 1'b1);

        // Flush on the response for 0x104, then flush during a stall.
        cycle();
        IF_Flush = 1'b1;
        cycle();
        check_ifid("fl", 32'h100, 32'h13, 1'b0);
        IF_Flush = 1'b0;
        cycle(); cycle();
        check_ifid("fl_next", 32'h108, 32'hA5A5_0108, 1'b1);
        IFIDWrite = 1'b0; IF_Flush = 1'b1;
        cycle();
        check_ifid("fl_hold", 32'h108, 32'hA5A5_0108, 1'b1);
        IFIDWrite = 1'b1; IF_Flush = 1'b0;
        cycle();
        check_ifid("fl_rel", 32'h10C, 32'hA5A5_010C, 1'b1);

        // Grant withheld, stray rvalid and a branch without PCWrite.
        gnt_en = 1'b0; stray_rv = 1'b1; PCWrite = 1'b0;
        branch_taken = 1'b1; branch_target = 32'h200;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("gw_req%0d", i), 32'(imem_req), 32'h1);
            chk($sformatf("gw_addr%0d", i), imem_addr, 32'h110);
        end
        chk("gw_valid", 32'(valid_IFID), 32'h0);
        gnt_en = 1'b1; stray_rv = 1'b0; PCWrite = 1'b1;
        branch_taken = 1'b0; branch_target = 32'h0;
        cycle(); cycle();
        check_ifid("gw_del", 32'h110, 32'hA5A5_0110, 1'b1);
        chk("nobr_addr", imem_addr, 32'h114);

        // Reset while WAITing, then a late response after release.
        cycle();
        rst_n = 1'b0; hold_rv = 1'b1;
        cycle();
        chk("mr_req", 32'(imem_req), 32'h0);
        chk("mr_addr", imem_addr, 32'h0);
        check_ifid("mr", 32'h0, 32'h13, 1'b0);
        rst_n = 1'b1; hold_rv = 1'b0; stray_rv = 1'b1;
        cycle();
        stray_rv = 1'b0;
        chk("mr_refetch", imem_addr, 32'h0);
        chk("mr_rreq", 32'(imem_req), 32'h1);
        chk("mr_late", 32'(valid_IFID), 32'h0);
        cycle(); cycle();
        check_ifid("mr_first", 32'h0, 32'hA5A5_0000, 1'b1);

        chk("no_dropped", 32'(seen_bad), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
